// File: rtl/pipelined_alu_md_if.sv
// Request/response bundle for pipelined_alu_md: operands and op code in,
// busy/done handshake and the Lo/Hi result pair with flags out.
interface pipelined_alu_md_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
);
    logic               start;
    logic [3:0]         ALUOperation;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [SHAMT_W-1:0] shamt;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   ALUResult;
    logic [WIDTH-1:0]   ALUResultHi;
    logic               Zero;
    logic               DivByZero;

    modport master (
        output start, ALUOperation, A, B, shamt,
        input  busy, done, ALUResult, ALUResultHi, Zero, DivByZero
    );

    modport slave (
        input  start, ALUOperation, A, B, shamt,
        output busy, done, ALUResult, ALUResultHi, Zero, DivByZero
    );
endinterface

// File: rtl/pipelined_alu_md.sv
// Sequential ALU with registered outputs, start/done handshake, and iterative
// unsigned multiply (shift-add) and restoring divide writing a Lo/Hi result pair.
module pipelined_alu_md #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input logic               clk,
    input logic               reset,
    pipelined_alu_md_if.slave bus
);

    localparam int unsigned CntW  = $clog2(WIDTH + 1);
    localparam int unsigned HalfW = WIDTH / 2;

    localparam logic [3:0] OpAnd   = 4'b0000;
    localparam logic [3:0] OpOr    = 4'b0001;
    localparam logic [3:0] OpNor   = 4'b0010;
    localparam logic [3:0] OpAdd   = 4'b0011;
    localparam logic [3:0] OpSub   = 4'b0100;
    localparam logic [3:0] OpLui   = 4'b0101;
    localparam logic [3:0] OpMultu = 4'b0110;
    localparam logic [3:0] OpDivu  = 4'b0111;
    localparam logic [3:0] OpSra   = 4'b1101;
    localparam logic [3:0] OpSrl   = 4'b1110;
    localparam logic [3:0] OpSll   = 4'b1111;

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             done_q, done_d;
    logic             zero_q, zero_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] single_res;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
    logic [WIDTH:0]   div_sh, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_n, div_quo_n;
    logic             last_iter;

    always_comb begin
        single_res = '0;
        case (bus.ALUOperation)
            OpAnd:   single_res = bus.A & bus.B;
            OpOr:    single_res = bus.A | bus.B;
            OpNor:   single_res = ~(bus.A | bus.B);
            OpAdd:   single_res = bus.A + bus.B;
            OpSub:   single_res = bus.A - bus.B;
            OpLui:   single_res = {bus.B[HalfW-1:0], {HalfW{1'b0}}};
            OpSra:   single_res = $signed(bus.B) >>> bus.shamt;
            OpSrl:   single_res = bus.B >> bus.shamt;
            OpSll:   single_res = bus.B << bus.shamt;
            default: single_res = '0;
        endcase
    end

    // Multiply: {hi, lo} holds {partial product, remaining multiplier bits}.
    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        mul_hi_n  = mul_sum[WIDTH:1];
        mul_lo_n  = {mul_sum[0], lo_q[WIDTH-1:1]};
        div_sh    = {hi_q, lo_q[WIDTH-1]};
        div_ge    = div_sh >= {1'b0, opb_q};
        div_diff  = div_sh - {1'b0, opb_q};
        div_rem_n = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
        div_quo_n = {lo_q[WIDTH-2:0], div_ge};
        last_iter = (cnt_q == CntW'(1));
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        res_d    = res_q;
        res_hi_d = res_hi_q;
        done_d   = 1'b0;
        zero_d   = zero_q;
        dbz_d    = dbz_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.ALUOperation == OpMultu ||
                        (bus.ALUOperation == OpDivu && bus.B != '0)) begin
                        hi_d    = '0;
                        lo_d    = bus.A;
                        opb_d   = bus.B;
                        cnt_d   = CntW'(WIDTH);
                        state_d = (bus.ALUOperation == OpMultu) ? StMul : StDiv;
                    end else if (bus.ALUOperation == OpDivu) begin
                        res_d    = '1;
                        res_hi_d = bus.A;
                        zero_d   = 1'b0;
                        dbz_d    = 1'b1;
                        done_d   = 1'b1;
                    end else begin
                        res_d    = single_res;
                        res_hi_d = '0;
                        zero_d   = (single_res == '0);
                        dbz_d    = 1'b0;
                        done_d   = 1'b1;
                    end
                end
            end
            StMul: begin
                hi_d  = mul_hi_n;
                lo_d  = mul_lo_n;
                cnt_d = cnt_q - CntW'(1);
                if (last_iter) begin
                    state_d  = StIdle;
                    res_d    = mul_lo_n;
                    res_hi_d = mul_hi_n;
                    zero_d   = (mul_lo_n == '0);
                    dbz_d    = 1'b0;
                    done_d   = 1'b1;
                end
            end
            StDiv: begin
                hi_d  = div_rem_n;
                lo_d  = div_quo_n;
                cnt_d = cnt_q - CntW'(1);
                if (last_iter) begin
                    state_d  = StIdle;
                    res_d    = div_quo_n;
                    res_hi_d = div_rem_n;
                    zero_d   = (div_quo_n == '0);
                    dbz_d    = 1'b0;
                    done_d   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            res_q    <= '0;
            res_hi_q <= '0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            done_q   <= done_d;
            zero_q   <= zero_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.busy        = (state_q != StIdle);
    assign bus.done        = done_q;
    assign bus.ALUResult   = res_q;
    assign bus.ALUResultHi = res_hi_q;
    assign bus.Zero        = zero_q;
    assign bus.DivByZero   = dbz_q;

endmodule

// File: tb/tb_pipelined_alu_md.sv
// Bench for pipelined_alu_md at WIDTH=32 and WIDTH=16: directed literal cases plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_pipelined_alu_md;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    pipelined_alu_md_if #(.WIDTH(32), .SHAMT_W(5)) if32 ();
    pipelined_alu_md_if #(.WIDTH(16), .SHAMT_W(4)) if16 ();

    pipelined_alu_md #(.WIDTH(32), .SHAMT_W(5)) dut32 (.clk(clk), .reset(reset), .bus(if32));
    pipelined_alu_md #(.WIDTH(16), .SHAMT_W(4)) dut16 (.clk(clk), .reset(reset), .bus(if16));

    // Model: an accepted MULTU/DIVU computes its answer at once and releases it
    // after 'left' clocks; everything else lands on the next edge.
    typedef struct packed {
        logic [31:0] left;
        logic [63:0] plo;
        logic [63:0] phi;
        logic [63:0] lo;
        logic [63:0] hi;
        logic        zero;
        logic        dbz;
        logic        done;
    } mst_t;

    mst_t m32, m16;
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic mst_t mstep(input mst_t s, input int w, input logic rst, input logic st,
                                   input logic [3:0] op, input logic [63:0] a,
                                   input logic [63:0] b, input int sh);
        mst_t        n;
        logic [63:0] mask, r, p, sx;
        n      = s;
        mask   = (64'd1 << w) - 64'd1;
        n.done = 1'b0;
        r      = '0;
        if (rst) begin
            n = '0;
        end else if (s.left != 0) begin
            n.left = s.left - 1;
            if (n.left == 0) begin
                n.done = 1'b1;
                n.lo   = s.plo;
                n.hi   = s.phi;
                n.zero = (s.plo == 0);
                n.dbz  = 1'b0;
            end
        end else if (st) begin
            if (op == 4'd6) begin
                p      = a * b;
                n.plo  = p & mask;
                n.phi  = (p >> w) & mask;
                n.left = 32'(w);
            end else if (op == 4'd7 && b != 0) begin
                n.plo  = a / b;
                n.phi  = a % b;
                n.left = 32'(w);
            end else if (op == 4'd7) begin
                n.done = 1'b1;
                n.lo   = mask;
                n.hi   = a;
                n.zero = 1'b0;
                n.dbz  = 1'b1;
            end else begin
                sx = b;
                if (b[w-1]) sx = b | ~mask;
                case (op)
                    4'd0:    r = a & b;
                    4'd1:    r = a | b;
                    4'd2:    r = ~(a | b) & mask;
                    4'd3:    r = (a + b) & mask;
                    4'd4:    r = (a - b) & mask;
                    4'd5:    r = (b & ((64'd1 << (w / 2)) - 64'd1)) << (w / 2);
                    4'd13:   r = (sx >> sh) & mask;
                    4'd14:   r = b >> sh;
                    4'd15:   r = (b << sh) & mask;
                    default: r = '0;
                endcase
                n.done = 1'b1;
                n.lo   = r;
                n.hi   = '0;
                n.zero = (r == 0);
                n.dbz  = 1'b0;
            end
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    endtask

    // Advance one clock: step the model on the edge, compare both DUTs mid-cycle.
    task automatic cyc();
        @(posedge clk);
        m32 = mstep(m32, 32, reset, if32.start, if32.ALUOperation, 64'(if32.A), 64'(if32.B),
                    int'(if32.shamt));
        m16 = mstep(m16, 16, reset, if16.start, if16.ALUOperation, 64'(if16.A), 64'(if16.B),
                    int'(if16.shamt));
        @(negedge clk);
        chk("u32 busy", 64'(if32.busy), 64'(m32.left != 0));
        chk("u32 done", 64'(if32.done), 64'(m32.done));
        chk("u32 ALUResult", 64'(if32.ALUResult), m32.lo);
        chk("u32 ALUResultHi", 64'(if32.ALUResultHi), m32.hi);
        chk("u32 Zero", 64'(if32.Zero), 64'(m32.zero));
        chk("u32 DivByZero", 64'(if32.DivByZero), 64'(m32.dbz));
        chk("u16 busy", 64'(if16.busy), 64'(m16.left != 0));
        chk("u16 done", 64'(if16.done), 64'(m16.done));
        chk("u16 ALUResult", 64'(if16.ALUResult), m16.lo);
        chk("u16 ALUResultHi", 64'(if16.ALUResultHi), m16.hi);
        chk("u16 Zero", 64'(if16.Zero), 64'(m16.zero));
        chk("u16 DivByZero", 64'(if16.DivByZero), 64'(m16.dbz));
    endtask

    task automatic drive32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh);
        if32.start = 1'b1; if32.ALUOperation = op; if32.A = a; if32.B = b; if32.shamt = sh;
    endtask

    task automatic drive16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] sh);
        if16.start = 1'b1; if16.ALUOperation = op; if16.A = a; if16.B = b; if16.shamt = sh;
    endtask

    function automatic logic [31:0] rnd_opnd();
        int unsigned k;
        k = $urandom_range(0, 7);
        if (k == 0) return 32'd0;
        if (k < 3) return 32'($urandom_range(0, 15));
        if (k == 3) return 32'hFFFF_FFFF;
        return 32'($urandom);
    endfunction

    function automatic logic [3:0] rnd_op();
        if ($urandom_range(0, 1) == 1) return ($urandom_range(0, 1) == 1) ? 4'd6 : 4'd7;
        return 4'($urandom_range(0, 15));
    endfunction

    initial begin
        reset = 1'b1;
        m32   = '0;
        m16   = '0;
        drive32(4'd0, 32'd0, 32'd0, 5'd0);
        drive16(4'd0, 16'd0, 16'd0, 4'd0);
        if32.start = 1'b0;
        if16.start = 1'b0;
        cyc();
        cyc();
        chk("reset busy", 64'(if32.busy), 64'd0);
        chk("reset result", 64'(if32.ALUResult), 64'd0);
        chk("reset zero", 64'(if32.Zero), 64'd0);
        reset = 1'b0;
        cyc();

        // SUB 5-5, then ADD wrap back-to-back
        drive32(4'b0100, 32'd5, 32'd5, 5'd0);
        cyc();
        chk("sub result", 64'(if32.ALUResult), 64'd0);
        chk("sub zero", 64'(if32.Zero), 64'd1);
        chk("sub done", 64'(if32.done), 64'd1);
        chk("sub busy", 64'(if32.busy), 64'd0);
        drive32(4'b0011, 32'hFFFF_FFFF, 32'd1, 5'd0);
        cyc();
        if32.start = 1'b0;
        chk("add result", 64'(if32.ALUResult), 64'd0);
        chk("add zero", 64'(if32.Zero), 64'd1);
        chk("add done b2b", 64'(if32.done), 64'd1);

        // MULTU max x max
        drive32(4'b0110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        cyc();
        if32.start = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            chk("mul busy", 64'(if32.busy), 64'd1);
            chk("mul early done", 64'(if32.done), 64'd0);
            cyc();
        end
        chk("mul hi", 64'(if32.ALUResultHi), 64'hFFFF_FFFE);
        chk("mul lo", 64'(if32.ALUResult), 64'h0000_0001);
        chk("mul done", 64'(if32.done), 64'd1);
        chk("mul busy end", 64'(if32.busy), 64'd0);
        cyc();
        chk("mul done once", 64'(if32.done), 64'd0);

        // DIVU 100/7 then divide by zero
        drive32(4'b0111, 32'd100, 32'd7, 5'd0);
        cyc();
        if32.start = 1'b0;
        repeat (32) cyc();
        chk("div quo", 64'(if32.ALUResult), 64'd14);
        chk("div rem", 64'(if32.ALUResultHi), 64'd2);
        chk("div dbz", 64'(if32.DivByZero), 64'd0);
        chk("div done", 64'(if32.done), 64'd1);
        drive32(4'b0111, 32'd5, 32'd0, 5'd0);
        cyc();
        if32.start = 1'b0;
        chk("div0 lo", 64'(if32.ALUResult), 64'hFFFF_FFFF);
        chk("div0 hi", 64'(if32.ALUResultHi), 64'd5);
        chk("div0 dbz", 64'(if32.DivByZero), 64'd1);
        chk("div0 busy", 64'(if32.busy), 64'd0);

        // Shifts and LUI
        drive32(4'b1101, 32'd0, 32'h8000_0000, 5'd4);
        cyc();
        chk("sra", 64'(if32.ALUResult), 64'hF800_0000);
        chk("sra clears dbz", 64'(if32.DivByZero), 64'd0);
        drive32(4'b1110, 32'd0, 32'h8000_0000, 5'd4);
        cyc();
        chk("srl", 64'(if32.ALUResult), 64'h0800_0000);
        drive32(4'b0101, 32'd0, 32'h0000_1234, 5'd0);
        cyc();
        if32.start = 1'b0;
        chk("lui", 64'(if32.ALUResult), 64'h1234_0000);

        // Ignored start while busy, then abort by reset (with a colliding start)
        drive32(4'b0110, 32'h0123_4567, 32'h0008_9ABC, 5'd0);
        cyc();
        if32.start = 1'b0;
        repeat (9) cyc();
        drive32(4'b0011, 32'd1, 32'd1, 5'd0);
        cyc();
        if32.start = 1'b0;
        chk("busy ignores start", 64'(if32.busy), 64'd1);
        chk("no done while busy", 64'(if32.done), 64'd0);
        repeat (9) cyc();
        reset = 1'b1;
        drive32(4'b0011, 32'd7, 32'd7, 5'd0);
        cyc();
        chk("abort busy", 64'(if32.busy), 64'd0);
        chk("abort done", 64'(if32.done), 64'd0);
        chk("abort lo", 64'(if32.ALUResult), 64'd0);
        chk("abort hi", 64'(if32.ALUResultHi), 64'd0);
        reset = 1'b0;
        drive32(4'b0011, 32'd2, 32'd3, 5'd0);
        cyc();
        if32.start = 1'b0;
        chk("post-reset add", 64'(if32.ALUResult), 64'd5);
        chk("post-reset done", 64'(if32.done), 64'd1);
        repeat (40) cyc();

        // WIDTH=16 MULTU max x max at cycle 17
        drive16(4'b0110, 16'hFFFF, 16'hFFFF, 4'd0);
        cyc();
        if16.start = 1'b0;
        repeat (16) cyc();
        chk("u16 mul hi", 64'(if16.ALUResultHi), 64'hFFFE);
        chk("u16 mul lo", 64'(if16.ALUResult), 64'h0001);
        chk("u16 mul done", 64'(if16.done), 64'd1);

        // Random traffic on both widths
        for (int n = 0; n < 1500; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            drive32(rnd_op(), rnd_opnd(), rnd_opnd(), 5'($urandom_range(0, 31)));
            drive16(rnd_op(), 16'(rnd_opnd()), 16'(rnd_opnd()), 4'($urandom_range(0, 15)));
            if32.start = ($urandom_range(0, 2) != 0);
            if16.start = ($urandom_range(0, 2) != 0);
            cyc();
        end
        reset      = 1'b0;
        if32.start = 1'b0;
        if16.start = 1'b0;
        repeat (40) cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipelined_alu_md.md
# pipelined_alu_md

Parametrised sequential ALU for the datapath. It extends the single-cycle logic/arithmetic/shift unit with registered outputs, a start/done handshake, arithmetic right shift, and iterative unsigned multiply and divide. Results land in a low/high result pair, the same way a HI/LO pair would. It sits between the register-file read stage and write-back, and the control unit stalls on `busy`.

## Interface
- `WIDTH`, 32, operand/result width; must be even and ≥ 4.
- `SHAMT_W`, 5, shift-amount width; must equal clog2(WIDTH).
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high; one clock; all state cleared on the edge where `reset`=1.
- `start`  in  1  request; sampled only when `busy`=0.
- `ALUOperation`  in  4  operation code.
- `A`, `B`  in  WIDTH  operands; captured on the accepting edge.
- `shamt`  in  SHAMT_W  shift amount; captured on the accepting edge.
- `busy`  out  1  multi-cycle operation in progress.
- `done`  out  1  one-cycle pulse; results are valid from this cycle onward.
- `ALUResult`  out  WIDTH  result: low product, or quotient.
- `ALUResultHi`  out  WIDTH  high product, or remainder; 0 for single-cycle ops.
- `Zero`  out  1  `ALUResult`==0, registered with the result.
- `DivByZero`  out  1  last DIVU had B==0; cleared by any other completed op.

## Operation
- Op codes:
  - AND 0000: A&B
  - OR 0001: A|B
  - NOR 0010: ~(A|B)
  - ADD 0011: A+B, wraps mod 2^WIDTH, no overflow flag
  - SUB 0100: A-B, wraps
  - LUI 0101: {B[WIDTH/2-1:0], WIDTH/2 zeros}
  - MULTU 0110: unsigned A×B, 2·WIDTH bits, split {Hi,Lo}
  - DIVU 0111: unsigned A/B; quotient to Lo, remainder to Hi
  - SRA 1101: B arithmetic right shift by shamt
  - SRL 1110: B logical right shift by shamt
  - SLL 1111: B left shift by shamt
  - All other codes: result 0, `Zero`=1, latency 1.
- FSM states: IDLE, MUL, DIV.
  - IDLE & start & single-cycle op → IDLE; outputs register on that edge.
  - IDLE & start & MULTU → MUL; operands latched, iteration counter loaded with WIDTH.
  - IDLE & start & DIVU & B≠0 → DIV; same latching.
  - IDLE & start & DIVU & B==0 → IDLE; ALUResult = all ones, ALUResultHi = A, `DivByZero`=1.
  - MUL/DIV: one iteration per cycle, counter decrements; on the edge where the counter reaches 0 → IDLE and results are loaded.
- MULTU: shift-add over a 2·WIDTH accumulator, one multiplier bit per cycle, LSB first.
- DIVU: restoring division, one quotient bit per cycle, MSB first. Remainder is always < B.
- Outputs hold their values between `done` pulses. Operand inputs are ignored while `busy`=1.
- `start` while `busy`=1 is ignored and not queued.
- `start` in the same cycle as `done` is accepted, because `busy` is already 0.
- Reset:
  - `busy`, `done`, `ALUResult`, `ALUResultHi`, `DivByZero` = 0, `Zero` = 0, state IDLE.
  - Reset during MUL/DIV aborts the operation: no `done`, outputs cleared.
  - Reset has priority over a simultaneous `start`.

## Timing
- Cycle 0 is the cycle in which `start`=1 is sampled with `busy`=0.
- Single-cycle ops and DIVU by zero: `done`=1 and results valid in cycle 1; `busy` stays 0.
- MULTU/DIVU: `busy`=1 in cycles 1..WIDTH. `done`=1, `busy`=0 and results valid in cycle WIDTH+1. Latency is 33 for WIDTH=32.
- Issue rate: one single-cycle op per clock, back-to-back, with `done` high on consecutive cycles.
- `Zero` and `DivByZero` change only on `done` edges or on reset.

## Test plan
- SUB with A=5, B=5 at cycle 0 → cycle 1: ALUResult=0, Zero=1, done=1, busy=0. Then ADD 0xFFFFFFFF+1 on the next cycle → ALUResult=0, Zero=1.
- MULTU with A=B=0xFFFFFFFF → busy high for cycles 1–32; cycle 33: ALUResultHi=0xFFFFFFFE, ALUResult=0x00000001, done pulses exactly once.
- DIVU with A=100, B=7 → cycle 33: ALUResult=14, ALUResultHi=2, DivByZero=0. DIVU with A=5, B=0 → cycle 1: ALUResult=0xFFFFFFFF, ALUResultHi=5, DivByZero=1.
- SRA with B=0x80000000, shamt=4 → 0xF8000000. SRL with the same operands → 0x08000000. LUI with B=0x00001234 → 0x12340000.
- Start MULTU; pulse `start` with ADD at cycle 10 → ADD is ignored. Assert reset at cycle 20 → no done, all outputs 0. A fresh ADD 2+3 after reset gives 5 at latency 1.
- WIDTH=16, SHAMT_W=4: MULTU 0xFFFF×0xFFFF → Hi=0xFFFE, Lo=0x0001 at cycle 17. Random MULTU/DIVU results checked against a reference model.
